// File: rtl/tennis_game_ctrl.sv
// Frame-rate game sequencer for the tennis screen: ball motion, paddle hits,
// serve/play/miss/game-over sequencing and score/miss counting.
module tennis_game_ctrl #(
    parameter int unsigned SCR_W        = 640,
    parameter int unsigned SCR_H        = 480,
    parameter int unsigned BORDER       = 8,
    parameter int unsigned BALL         = 16,
    parameter int unsigned PADDLE_X     = 616,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned SERVE_X      = 64,
    parameter int unsigned SERVE_Y      = 32,
    parameter int unsigned STEP_INIT    = 1,
    parameter int unsigned STEP_MAX     = 4,
    parameter int unsigned HITS_PER_UP  = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MISS_FRAMES  = 60,
    parameter int unsigned MAX_MISSES   = 3
) (
    input  logic        pixel_clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        start_p,
    input  logic        pause_p,
    input  logic [10:0] paddle_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        ball_visible,
    output logic [7:0]  score,
    output logic [1:0]  misses,
    output logic [1:0]  state,
    output logic        game_over
);

    localparam logic [10:0] X_MIN      = 11'(BORDER);
    localparam logic [10:0] Y_MIN      = 11'(BORDER);
    localparam logic [10:0] Y_MAX      = 11'(SCR_H - BORDER - BALL);
    localparam logic [10:0] HX         = 11'(PADDLE_X - BALL);
    localparam logic [10:0] MISS_X     = 11'(SCR_W - BALL);
    localparam logic [10:0] SX         = 11'(SERVE_X);
    localparam logic [10:0] SY         = 11'(SERVE_Y);
    localparam logic [2:0]  STEP_I     = 3'(STEP_INIT);
    localparam logic [2:0]  STEP_M     = 3'(STEP_MAX);
    localparam logic [2:0]  HIT_UP     = 3'(HITS_PER_UP);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  MISS_LAST  = 8'(MISS_FRAMES - 1);
    localparam logic [1:0]  MAX_M      = 2'(MAX_MISSES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_MISS  = 2'd3
    } state_t;

    state_t      st, st_nx;
    logic [10:0] x, y, x_nx, y_nx;
    logic        dir_x, dir_y, dir_x_nx, dir_y_nx;
    logic [2:0]  step, step_nx;
    logic [2:0]  hit_cnt, hit_cnt_nx;
    logic [7:0]  frame_cnt, frame_cnt_nx;
    logic [7:0]  score_r, score_nx;
    logic [1:0]  miss_r, miss_nx;
    logic        vis, vis_nx, over, over_nx, paused, paused_nx;

    logic [10:0] step11, nx, ny;
    logic [11:0] y_bot, pad_bot;
    logic        hit_zone;

    always_comb begin
        step11   = {8'd0, step};
        nx       = dir_x ? x + step11 : x - step11;
        ny       = dir_y ? y + step11 : y - step11;
        y_bot    = {1'b0, y} + 12'(BALL);
        pad_bot  = {1'b0, paddle_y} + 12'(PADDLE_H);
        hit_zone = (y_bot > {1'b0, paddle_y}) && ({1'b0, y} < pad_bot);
    end

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            st        <= S_IDLE;
            x         <= SX;
            y         <= SY;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            step      <= STEP_I;
            hit_cnt   <= '0;
            frame_cnt <= '0;
            score_r   <= '0;
            miss_r    <= '0;
            vis       <= 1'b1;
            over      <= 1'b0;
            paused    <= 1'b0;
        end else begin
            st        <= st_nx;
            x         <= x_nx;
            y         <= y_nx;
            dir_x     <= dir_x_nx;
            dir_y     <= dir_y_nx;
            step      <= step_nx;
            hit_cnt   <= hit_cnt_nx;
            frame_cnt <= frame_cnt_nx;
            score_r   <= score_nx;
            miss_r    <= miss_nx;
            vis       <= vis_nx;
            over      <= over_nx;
            paused    <= paused_nx;
        end
    end

    always_comb begin
        st_nx        = st;
        x_nx         = x;
        y_nx         = y;
        dir_x_nx     = dir_x;
        dir_y_nx     = dir_y;
        step_nx      = step;
        hit_cnt_nx   = hit_cnt;
        frame_cnt_nx = frame_cnt;
        score_nx     = score_r;
        miss_nx      = miss_r;
        vis_nx       = vis;
        over_nx      = over;
        paused_nx    = 1'b0;
        unique case (st)
            S_IDLE: begin
                x_nx     = SX;
                y_nx     = SY;
                dir_x_nx = 1'b1;
                dir_y_nx = 1'b1;
                vis_nx   = 1'b1;
                if (start_p) begin
                    st_nx        = S_SERVE;
                    score_nx     = '0;
                    miss_nx      = '0;
                    over_nx      = 1'b0;
                    hit_cnt_nx   = '0;
                    step_nx      = STEP_I;
                    frame_cnt_nx = '0;
                end
            end
            S_SERVE: begin
                x_nx     = SX;
                y_nx     = SY;
                dir_x_nx = 1'b1;
                dir_y_nx = 1'b1;
                if (frame_tick) begin
                    if (frame_cnt == SERVE_LAST) begin
                        st_nx        = S_PLAY;
                        frame_cnt_nx = '0;
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // A same-cycle pause press is applied before the tick is considered.
                paused_nx = paused ^ pause_p;
                if (frame_tick && !paused_nx) begin
                    if (dir_x && nx >= MISS_X) begin
                        st_nx        = S_MISS;
                        miss_nx      = miss_r + 2'd1;
                        vis_nx       = 1'b0;
                        frame_cnt_nx = '0;
                        paused_nx    = 1'b0;
                    end else begin
                        if (dir_x && x < HX && nx >= HX && hit_zone) begin
                            x_nx     = HX;
                            dir_x_nx = 1'b0;
                            score_nx = (score_r != 8'hFF) ? score_r + 8'd1 : score_r;
                            if (hit_cnt + 3'd1 == HIT_UP) begin
                                hit_cnt_nx = '0;
                                step_nx    = (step < STEP_M) ? step + 3'd1 : step;
                            end else begin
                                hit_cnt_nx = hit_cnt + 3'd1;
                            end
                        end else if (!dir_x && x <= X_MIN + step11) begin
                            x_nx     = X_MIN;
                            dir_x_nx = 1'b1;
                        end else begin
                            x_nx = nx;
                        end
                        if (!dir_y && y <= Y_MIN + step11) begin
                            y_nx     = Y_MIN;
                            dir_y_nx = 1'b1;
                        end else if (dir_y && ny >= Y_MAX) begin
                            y_nx     = Y_MAX;
                            dir_y_nx = 1'b0;
                        end else begin
                            y_nx = ny;
                        end
                    end
                end
            end
            S_MISS: begin
                vis_nx = 1'b0;
                if (frame_tick) begin
                    if (frame_cnt == MISS_LAST) begin
                        frame_cnt_nx = '0;
                        x_nx         = SX;
                        y_nx         = SY;
                        dir_x_nx     = 1'b1;
                        dir_y_nx     = 1'b1;
                        vis_nx       = 1'b1;
                        if (miss_r == MAX_M) begin
                            st_nx   = S_IDLE;
                            over_nx = 1'b1;
                        end else begin
                            st_nx = S_SERVE;
                        end
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
            end
            default: st_nx = S_IDLE;
        endcase
    end

    assign ball_x       = x;
    assign ball_y       = y;
    assign ball_visible = vis;
    assign score        = score_r;
    assign misses       = miss_r;
    assign state        = st;
    assign game_over    = over;

endmodule

// File: tb/tb_tennis_game_ctrl.sv
// Bench for tennis_game_ctrl: directed serve/pause/reset sequence, then random
// play checked every cycle against an integer-velocity model of the game rules.
module tb_tennis_game_ctrl;

    logic        pixel_clk = 1'b0;
    logic        resetn;
    logic        frame_tick, start_p, pause_p;
    logic [10:0] paddle_y;
    logic [10:0] ball_x, ball_y;
    logic        ball_visible, game_over;
    logic [7:0]  score;
    logic [1:0]  misses, state;

    int errors = 0;
    int checks = 0;

    localparam int IDLE = 0, SERVE = 1, PLAY = 2, MISS = 3;

    // Reference game state: position plus signed velocity sign per axis.
    int m_st, mx, my, vx, vy, mstep, mscore, mmiss, mover, mhits, mframes, mvis, mpaused;

    tennis_game_ctrl dut (
        .pixel_clk    (pixel_clk),
        .resetn       (resetn),
        .frame_tick   (frame_tick),
        .start_p      (start_p),
        .pause_p      (pause_p),
        .paddle_y     (paddle_y),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_visible (ball_visible),
        .score        (score),
        .misses       (misses),
        .state        (state),
        .game_over    (game_over)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task model_reset();
        m_st = IDLE; mx = 64; my = 32; vx = 1; vy = 1; mstep = 1;
        mscore = 0; mmiss = 0; mover = 0; mhits = 0; mframes = 0; mvis = 1; mpaused = 0;
    endtask

    task model_serve_pos();
        mx = 64; my = 32; vx = 1; vy = 1;
    endtask

    task model_edge(input bit tk, input bit st_p, input bit ps_p, input int py);
        int tx, ty;
        case (m_st)
            IDLE: if (st_p) begin
                m_st = SERVE; mscore = 0; mmiss = 0; mover = 0; mhits = 0;
                mstep = 1; mframes = 0; model_serve_pos();
            end
            SERVE: if (tk) begin
                mframes++;
                if (mframes == 60) begin m_st = PLAY; mframes = 0; end
            end
            PLAY: begin
                if (ps_p) mpaused = !mpaused;
                if (tk && !mpaused) begin
                    tx = mx + vx * mstep;
                    ty = my + vy * mstep;
                    if (vx > 0 && tx >= 624) begin
                        m_st = MISS; mmiss++; mvis = 0; mframes = 0; mpaused = 0;
                    end else begin
                        if (vx > 0 && mx < 600 && tx >= 600 && my + 16 > py && my < py + 64) begin
                            mx = 600; vx = -1;
                            if (mscore < 255) mscore++;
                            mhits++;
                            if (mhits == 4) begin
                                mhits = 0;
                                if (mstep < 4) mstep++;
                            end
                        end else if (vx < 0 && tx <= 8) begin
                            mx = 8; vx = 1;
                        end else begin
                            mx = tx;
                        end
                        if (vy < 0 && ty <= 8) begin my = 8; vy = 1; end
                        else if (vy > 0 && ty >= 456) begin my = 456; vy = -1; end
                        else my = ty;
                    end
                end
            end
            default: if (tk) begin
                mframes++;
                if (mframes == 60) begin
                    mframes = 0; mvis = 1; model_serve_pos();
                    if (mmiss == 3) begin m_st = IDLE; mover = 1; end
                    else m_st = SERVE;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("ball_x", int'(ball_x), mx);
        check_val("ball_y", int'(ball_y), my);
        check_val("ball_visible", int'(ball_visible), mvis);
        check_val("score", int'(score), mscore);
        check_val("misses", int'(misses), mmiss);
        check_val("state", int'(state), m_st);
        check_val("game_over", int'(game_over), mover);
    endtask

    task automatic check_reset_consts();
        check_val("rst_ball_x", int'(ball_x), 64);
        check_val("rst_ball_y", int'(ball_y), 32);
        check_val("rst_visible", int'(ball_visible), 1);
        check_val("rst_score", int'(score), 0);
        check_val("rst_misses", int'(misses), 0);
        check_val("rst_state", int'(state), 0);
        check_val("rst_game_over", int'(game_over), 0);
    endtask

    task automatic run_cycle(input bit tk, input bit st_p, input bit ps_p);
        frame_tick = tk; start_p = st_p; pause_p = ps_p;
        @(posedge pixel_clk);
        model_edge(tk, st_p, ps_p, int'(paddle_y));
        @(negedge pixel_clk);
        frame_tick = 1'b0; start_p = 1'b0; pause_p = 1'b0;
        compare_all();
    endtask

    task automatic reset_pulse();
        frame_tick = 1'b0; start_p = 1'b0; pause_p = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        check_reset_consts();
        @(negedge pixel_clk);
        compare_all();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; frame_tick = 1'b0; start_p = 1'b0; pause_p = 1'b0;
        paddle_y = 11'd300;
        model_reset();
        @(negedge pixel_clk);
        check_reset_consts();
        resetn = 1'b1;

        run_cycle(1'b0, 1'b1, 1'b0);
        check_val("start_state", int'(state), SERVE);
        for (int t = 1; t <= 60; t++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            if (t == 59) check_val("serve_hold", int'(state), SERVE);
            run_cycle(1'b0, 1'b0, 1'b0);
        end
        check_val("play_at_60", int'(state), PLAY);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_val("first_x", int'(ball_x), 65);
        check_val("first_y", int'(ball_y), 33);

        run_cycle(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 10; t++) run_cycle(1'b1, 1'b0, 1'b0);
        check_val("paused_x", int'(ball_x), 65);
        check_val("paused_y", int'(ball_y), 33);
        run_cycle(1'b0, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_val("resume_x", int'(ball_x), 66);
        check_val("resume_y", int'(ball_y), 34);

        reset_pulse();

        for (int c = 0; c < 30000 && errors < 20; c++) begin
            if (c == 15000) reset_pulse();
            if ($urandom_range(4) != 0) begin
                int p;
                p = my - int'($urandom_range(47));
                if (p < 0) p = 0;
                paddle_y = 11'(p);
            end else begin
                paddle_y = 11'($urandom_range(416));
            end
            run_cycle($urandom_range(2) == 0, $urandom_range(49) == 0,
                      $urandom_range(299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
